// File: rtl/ctrl_pipe_mc_pkg.sv
// ctrl_pipe_mc_pkg: shared types and constants for the controller pipeline.
//   - div_state_e : divide handshake FSM states
//   - stage_sel_e : per-stage register update select
//   - flat_width(): width of the flat stage bus
package ctrl_pipe_mc_pkg;

   localparam int unsigned CW_DEFAULT      = 20;
   localparam int unsigned STAGES_DEFAULT  = 3;
   // Must match the bit the decoders use to flag a divide in the control word.
   localparam int unsigned DIV_BIT_DEFAULT = 6;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StDone = 2'b10
   } div_state_e;

   typedef enum logic [1:0] {
      SelHold   = 2'b00,
      SelBubble = 2'b01,
      SelLoad   = 2'b10
   } stage_sel_e;

   function automatic int unsigned flat_width(input int unsigned cw, input int unsigned stages);
      return cw * stages;
   endfunction

endpackage

// File: rtl/ctrl_pipe_mc_stage_reg.sv
// ctrl_stage_reg: one pipeline stage (control word + valid) with async reset.
//   clk, rst        : clock, async active-high reset
//   sel             : hold / bubble / load
//   d_ctrl, d_valid : incoming stage contents
//   q_ctrl, q_valid : registered stage contents
module ctrl_stage_reg
   import ctrl_pipe_mc_pkg::*;
#(
   parameter int unsigned CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  stage_sel_e    sel,
   input  logic [CW-1:0] d_ctrl,
   input  logic          d_valid,
   output logic [CW-1:0] q_ctrl,
   output logic          q_valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_ctrl  <= '0;
         q_valid <= 1'b0;
      end else begin
         unique case (sel)
            SelLoad: begin
               q_ctrl  <= d_ctrl;
               q_valid <= d_valid;
            end
            // A bubble clears the whole word so no enable can leak through.
            SelBubble: begin
               q_ctrl  <= '0;
               q_valid <= 1'b0;
            end
            default: begin
               q_ctrl  <= q_ctrl;
               q_valid <= q_valid;
            end
         endcase
      end
   end

endmodule

// File: rtl/ctrl_pipe_mc.sv
// ctrl_pipe_mc: control-word pipeline from Decode through STAGES stages
// (stage 0 = Execute) with valid bits, global hold, Execute bubble and a
// multi-cycle divide handshake.
//   ctrlD, validD       : decoded control word and its valid
//   flushE              : bubble into Execute
//   hold                : freeze every stage
//   div_ready           : divider result pulse
//   ctrl_o, valid_o     : stage k at ctrl_o[k*CW +: CW], valid_o[k]
//   div_start           : launch pulse to the divider
//   div_stall           : freeze PC/Fetch/Decode/Execute
//   div_busy            : divide in flight or result waiting on hold
module ctrl_pipe_mc
   import ctrl_pipe_mc_pkg::*;
#(
   parameter int unsigned CW      = CW_DEFAULT,
   parameter int unsigned STAGES  = STAGES_DEFAULT,
   parameter int unsigned DIV_BIT = DIV_BIT_DEFAULT
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [CW-1:0]                     ctrlD,
   input  logic                              validD,
   input  logic                              flushE,
   input  logic                              hold,
   input  logic                              div_ready,
   output logic [flat_width(CW, STAGES)-1:0] ctrl_o,
   output logic [STAGES-1:0]                 valid_o,
   output logic                              div_start,
   output logic                              div_stall,
   output logic                              div_busy
);

   div_state_e state_q, state_d;
   stage_sel_e stage_sel [STAGES];
   logic       exe_div;

   assign exe_div = valid_o[0] & ctrl_o[DIV_BIT];

   // Stage registers; stage 0 is fed from Decode, stage k from stage k-1.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CW-1:0] d_ctrl;
      logic          d_valid;
      if (k == 0) begin : g_first
         assign d_ctrl  = ctrlD;
         assign d_valid = validD;
      end else begin : g_rest
         assign d_ctrl  = ctrl_o[(k-1)*CW +: CW];
         assign d_valid = valid_o[k-1];
      end
      ctrl_stage_reg #(
         .CW (CW)
      ) u_reg (
         .clk     (clk),
         .rst     (rst),
         .sel     (stage_sel[k]),
         .d_ctrl  (d_ctrl),
         .d_valid (d_valid),
         .q_ctrl  (ctrl_o[k*CW +: CW]),
         .q_valid (valid_o[k])
      );
   end

   // Update select, highest priority first: hold, divide stall, flush.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         stage_sel[k] = SelLoad;
      end
      if (hold) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_sel[k] = SelHold;
         end
      end else if (div_stall) begin
         stage_sel[0] = SelHold;
         stage_sel[1] = SelBubble;
      end else if (flushE) begin
         stage_sel[0] = SelBubble;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      div_stall = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (exe_div) begin
               div_stall = 1'b1;
               if (!hold) begin
                  div_start = 1'b1;
                  state_d   = StBusy;
               end
            end
         end
         StBusy: begin
            if (div_ready) begin
               // A result arriving under hold must be remembered until hold drops.
               state_d = hold ? StDone : StIdle;
            end else begin
               div_stall = 1'b1;
            end
         end
         StDone: begin
            if (hold) begin
               div_stall = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign div_busy = (state_q != StIdle);

endmodule
